player_state_anim: RTL and testbench

//  Per-player animation/motion controller; drives the sprite mapper's anim_state/anim_frame/facing/pos inputs.

---
 rtl/player_state_anim.sv | 147 ++++++++++++++
 tb/tb_player_state_anim.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/player_state_anim.sv
// player_state_anim: per-player animation/motion controller feeding the sprite mapper.
// Samples buttons once per video frame (frame_tick), runs the IDLE/MOVE/ATK1(/HIT) state
// machine, steps the animation frame counter and keeps pos_x inside [X_MIN, X_MAX].
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   frame_tick        one-cycle pulse per video frame; all state updates happen on it
//   btn_left/right    movement levels; both or neither means no movement
//   btn_atk           attack level, rising edge latched until the next tick
//   hit_in            hit pulse, only honoured when PLAYER_HITSTUN_EN is defined
//   anim_state        0=IDLE 1=MOVE 3=ATK1 5=HIT
//   anim_frame        frame index within the current state
//   facing_right      sprite orientation
//   pos_x             sprite left edge
//   atk_active        attack hitbox window, decoded directly from state/frame registers
//   anim_done         one-cycle pulse when a one-shot action (ATK1/HIT) completes
// Optional feature: define PLAYER_HITSTUN_EN to enable the HIT (hitstun) state.
module player_state_anim #(
  parameter int FRAME_DIV   = 4,
  parameter int IDLE_FRAMES = 10,
  parameter int RUN_FRAMES  = 8,
  parameter int ATK1_FRAMES = 18,
  parameter int HIT_FRAMES  = 6,
  parameter int ATK_ON      = 7,
  parameter int ATK_OFF     = 11,
  parameter int MOVE_STEP   = 2,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 514,
  parameter int START_X     = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_atk,
  input  logic       hit_in,
  output logic [3:0] anim_state,
  output logic [5:0] anim_frame,
  output logic       facing_right,
  output logic [9:0] pos_x,
  output logic       atk_active,
  output logic       anim_done
);
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_MOVE = 4'd1,
    S_ATK1 = 4'd3,
    S_HIT  = 4'd5
  } state_t;
  state_t state_q, state_d, loop_nxt;
  logic [5:0] frame_q, frame_d, loop_last, shot_last;
  logic [DW-1:0] div_q, div_d, div_inc;
  logic [9:0] pos_q, pos_d, pos_r, pos_l;
  logic [10:0] pos_sum;
  logic facing_q, facing_d, done_q, done_d;
  logic atk_prev_q, atk_pend_q, atk_pend_d;
  logic rise, go_r, go_l, wrap, hit_take;
`ifdef PLAYER_HITSTUN_EN
  logic hit_pend_q, hit_pend_d;
  assign hit_take = hit_pend_q;
  assign hit_pend_d = hit_in | (hit_pend_q & ~frame_tick);
`else
  logic unused_hit;
  assign unused_hit = hit_in;
  assign hit_take = 1'b0;
`endif
  always_comb begin
    rise = btn_atk & ~atk_prev_q;
    go_r = btn_right & ~btn_left;
    go_l = btn_left & ~btn_right;
    wrap = div_q == DW'(FRAME_DIV - 1);
    div_inc = wrap ? '0 : div_q + DW'(1);
    loop_last = (state_q == S_MOVE) ? 6'(RUN_FRAMES - 1) : 6'(IDLE_FRAMES - 1);
    shot_last = (state_q == S_HIT) ? 6'(HIT_FRAMES - 1) : 6'(ATK1_FRAMES - 1);
    loop_nxt = atk_pend_q ? S_ATK1 : (go_r | go_l) ? S_MOVE : S_IDLE;
    // 11-bit sum so a right step near X_MAX saturates instead of wrapping
    pos_sum = {1'b0, pos_q} + 11'(MOVE_STEP);
    pos_r = (pos_sum > 11'(X_MAX)) ? 10'(X_MAX) : pos_sum[9:0];
    pos_l = (pos_q < 10'(X_MIN + MOVE_STEP)) ? 10'(X_MIN) : pos_q - 10'(MOVE_STEP);
    // a pending attack lives for one tick only: consumed or dropped, never queued
    atk_pend_d = rise | (atk_pend_q & ~frame_tick);
    state_d = state_q;
    frame_d = frame_q;
    div_d = div_q;
    facing_d = facing_q;
    pos_d = pos_q;
    done_d = 1'b0;
    if (frame_tick) begin
      if (hit_take) begin
        state_d = S_HIT;
        frame_d = '0;
        div_d = '0;
      end else if (state_q == S_IDLE || state_q == S_MOVE) begin
        state_d = loop_nxt;
        div_d = (loop_nxt == state_q) ? div_inc : '0;
        frame_d = (loop_nxt != state_q) ? '0 : !wrap ? frame_q :
                  (frame_q == loop_last) ? '0 : frame_q + 6'd1;
        if (loop_nxt == S_MOVE) begin
          facing_d = go_r;
          pos_d = go_r ? pos_r : pos_l;
        end
      end else if (wrap && frame_q == shot_last) begin
        state_d = S_IDLE;
        frame_d = '0;
        div_d = '0;
        done_d = 1'b1;
      end else begin
        div_d = div_inc;
        frame_d = wrap ? frame_q + 6'd1 : frame_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      div_q <= '0;
      facing_q <= 1'b1;
      pos_q <= 10'(START_X);
      done_q <= 1'b0;
      atk_prev_q <= 1'b0;
      atk_pend_q <= 1'b0;
`ifdef PLAYER_HITSTUN_EN
      hit_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      div_q <= div_d;
      facing_q <= facing_d;
      pos_q <= pos_d;
      done_q <= done_d;
      atk_prev_q <= btn_atk;
      atk_pend_q <= atk_pend_d;
`ifdef PLAYER_HITSTUN_EN
      hit_pend_q <= hit_pend_d;
`endif
    end
  end
  assign anim_state = state_q;
  assign anim_frame = frame_q;
  assign facing_right = facing_q;
  assign pos_x = pos_q;
  assign anim_done = done_q;
  assign atk_active = (state_q == S_ATK1) && (frame_q >= 6'(ATK_ON)) && (frame_q <= 6'(ATK_OFF));
endmodule

// File: tb/tb_player_state_anim.sv
// tb_player_state_anim: directed stimulus, tick-count reference model and literal checks.
module tb_player_state_anim;
  localparam int DIV = 4, IDLE_N = 10, RUN_N = 8, ATK_N = 18, HIT_N = 6;
`ifdef PLAYER_HITSTUN_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_atk = 1'b0, hit_in = 1'b0;
  logic [3:0] anim_state;
  logic [5:0] anim_frame;
  logic facing_right, atk_active, anim_done;
  logic [9:0] pos_x;
  int checks = 0, errors = 0, done_cnt = 0;
  bit cmp_en = 1'b0;
  player_state_anim dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_left(btn_left),
    .btn_right(btn_right), .btn_atk(btn_atk), .hit_in(hit_in), .anim_state(anim_state),
    .anim_frame(anim_frame), .facing_right(facing_right), .pos_x(pos_x),
    .atk_active(atk_active), .anim_done(anim_done)
  );
  always #5 clk = ~clk;
  // model: state plus number of ticks spent in it; frame is derived by division
  int m_state, m_t, m_pos, tgt;
  bit m_face, m_done, m_pend, m_hpend, m_prev, rise;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_t = 0; m_pos = 100; m_face = 1; m_done = 0;
      m_pend = 0; m_hpend = 0; m_prev = 0;
    end else begin
      rise = btn_atk && !m_prev;
      m_prev = btn_atk;
      m_done = 0;
      if (frame_tick) begin
        if (HS && m_hpend) begin
          m_state = 5; m_t = 0;
        end else if (m_state < 2) begin
          tgt = m_pend ? 3 : (btn_left != btn_right) ? 1 : 0;
          if (tgt == 1) begin
            m_face = btn_right;
            m_pos = m_pos + (btn_right ? 2 : -2);
            if (m_pos < 0) m_pos = 0;
            if (m_pos > 514) m_pos = 514;
          end
          m_t = (tgt == m_state) ? m_t + 1 : 0;
          m_state = tgt;
        end else begin
          m_t++;
          if (m_t == ((m_state == 3) ? ATK_N : HIT_N) * DIV) begin
            m_state = 0; m_t = 0; m_done = 1;
          end
        end
        m_pend = rise;
        m_hpend = HS && hit_in;
      end else begin
        m_pend = m_pend || rise;
        m_hpend = m_hpend || (HS && hit_in);
      end
    end
  end
  function automatic int exp_frame();
    return (m_state == 0) ? (m_t / DIV) % IDLE_N : (m_state == 1) ? (m_t / DIV) % RUN_N : m_t / DIV;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (anim_done) done_cnt++;
    if (cmp_en) begin
      chk("m_state", int'(anim_state), m_state);
      chk("m_frame", int'(anim_frame), exp_frame());
      chk("m_facing", int'(facing_right), int'(m_face));
      chk("m_pos", int'(pos_x), m_pos);
      chk("m_atk", int'(atk_active), int'(m_state == 3 && exp_frame() >= 7 && exp_frame() <= 11));
      chk("m_done", int'(anim_done), int'(m_done));
    end
  end
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask
  task automatic run_to_done(input string nm, input int exp_ticks, input int exp_atk);
    int n, na;
    n = 0; na = 0;
    while (n <= 200 && !anim_done) begin
      tick(); n++;
      if (atk_active) na++;
    end
    chk({nm, "_ticks"}, n, exp_ticks);
    chk({nm, "_atk_ticks"}, na, exp_atk);
    chk({nm, "_end_state"}, int'(anim_state), 0);
  endtask
  task automatic atk_pulse();
    @(negedge clk) btn_atk = 1'b1;
    @(negedge clk) btn_atk = 1'b0;
  endtask
  initial begin
    int d0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    chk("rst_state", int'(anim_state), 0);
    chk("rst_frame", int'(anim_frame), 0);
    chk("rst_facing", int'(facing_right), 1);
    chk("rst_pos", int'(pos_x), 100);
    chk("rst_done", int'(anim_done), 0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 4) chk("idle_t4", int'(anim_frame), 1);
      if (k == 36) chk("idle_t36", int'(anim_frame), 9);
      if (k == 40) chk("idle_t40", int'(anim_frame), 0);
    end
    btn_left = 1'b1;
    repeat (48) tick();
    chk("walk_pos", int'(pos_x), 4);
    btn_left = 1'b0;
    tick();
    chk("walk_stop", int'(anim_state), 0);
    btn_left = 1'b1;
    tick();
    chk("clamp_state", int'(anim_state), 1);
    chk("clamp_frame", int'(anim_frame), 0);
    chk("clamp_face", int'(facing_right), 0);
    chk("clamp_pos1", int'(pos_x), 2);
    tick();
    chk("clamp_pos2", int'(pos_x), 0);
    tick();
    chk("clamp_pos3", int'(pos_x), 0);
    atk_pulse();
    btn_left = 1'b0;
    btn_right = 1'b1;
    tick();
    chk("atk_entry", int'(anim_state), 3);
    chk("atk_frame0", int'(anim_frame), 0);
    run_to_done("atk", 72, 20);
    chk("atk_pos", int'(pos_x), 0);
    chk("atk_face", int'(facing_right), 0);
    repeat (3) tick();
    chk("right_pos", int'(pos_x), 6);
    btn_right = 1'b0;
    btn_left = 1'b1;
    tick();
    chk("left_face", int'(facing_right), 0);
    btn_right = 1'b1;
    tick();
    chk("both_state", int'(anim_state), 0);
    chk("both_face", int'(facing_right), 0);
    chk("both_pos", int'(pos_x), 4);
    btn_left = 1'b0;
    btn_right = 1'b0;
    @(negedge clk) begin frame_tick = 1'b1; btn_atk = 1'b1; end
    @(negedge clk) begin frame_tick = 1'b0; btn_atk = 1'b0; end
    chk("same_clk_hold", int'(anim_state), 0);
    tick();
    chk("same_clk_take", int'(anim_state), 3);
`ifdef PLAYER_HITSTUN_EN
    repeat (36) tick();
    chk("hs_frame9", int'(anim_frame), 9);
    @(negedge clk) hit_in = 1'b1;
    @(negedge clk) hit_in = 1'b0;
    tick();
    chk("hs_state", int'(anim_state), 5);
    chk("hs_frame", int'(anim_frame), 0);
    chk("hs_atk", int'(atk_active), 0);
    run_to_done("hit", 24, 0);
    atk_pulse();
    tick();
    chk("hs_reatk", int'(anim_state), 3);
`endif
    repeat (20) tick();
    chk("mid_atk_frame", int'(anim_frame), 5);
    d0 = done_cnt;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", int'(anim_state), 0);
    chk("arst_frame", int'(anim_frame), 0);
    chk("arst_facing", int'(facing_right), 1);
    chk("arst_pos", int'(pos_x), 100);
    chk("arst_atk", int'(atk_active), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) tick();
    chk("arst_no_done", done_cnt, d0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
